// File: rtl/glue_ctrl.sv
// 68000 bus glue: region decode, boot ROM overlay, wait-state DTACK and BERR generation.
// Optional bus timeout is enabled by defining GLUE_BUS_TIMEOUT_EN.
module glue_ctrl #(
  parameter int BOOT_READS = 4,
  parameter int ROM_WAIT   = 2,
  parameter int RAM_WAIT   = 0,
  parameter int IO_WAIT    = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] addr_in,
  input  logic [2:0]  fc,
  input  logic        as_n,
  input  logic        read,
  input  logic        io_ready_n,
  output logic        dtack_n,
  output logic        berr_n,
  output logic        rom_enable_n,
  output logic        ram_enable_n,
  output logic        io_enable_n
);
  localparam int MAXW  = (ROM_WAIT > RAM_WAIT) ? ((ROM_WAIT > IO_WAIT) ? ROM_WAIT : IO_WAIT)
                                               : ((RAM_WAIT > IO_WAIT) ? RAM_WAIT : IO_WAIT);
  localparam int WW    = (MAXW < 1) ? 1 : $clog2(MAXW + 1);
  localparam int BW    = (BOOT_READS < 1) ? 1 : $clog2(BOOT_READS + 1);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_ACK, S_ERR} state_t;
  typedef enum logic [1:0] {R_RAM, R_IO, R_ROM, R_NONE} region_t;

  state_t        state_q;
  region_t       region_q, region_d;
  logic          rd_q;
  logic [WW-1:0] cnt_q, wait_d;
  logic [BW-1:0] boot_q;
  logic          err_d;
`ifdef GLUE_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] tmo_q;
`endif

  // Only the top address nibble and the supervisor bit take part in decoding.
  logic unused_bits;
  assign unused_bits = ^{addr_in[7:0], fc[1:0]};

  always_comb begin
    region_d = R_NONE;
    if (read && boot_q != '0)       region_d = R_ROM;
    else if (addr_in[11:8] <= 4'h7) region_d = R_RAM;
    else if (addr_in[11:8] == 4'hE) region_d = R_IO;
    else if (addr_in[11:8] == 4'hF) region_d = R_ROM;
    err_d = (region_d == R_NONE) || (region_d == R_IO && !fc[2]) || (region_d == R_ROM && !read);
    case (region_d)
      R_RAM:   wait_d = WW'(RAM_WAIT);
      R_IO:    wait_d = WW'(IO_WAIT);
      default: wait_d = WW'(ROM_WAIT);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      region_q     <= R_NONE;
      rd_q         <= 1'b0;
      cnt_q        <= '0;
      boot_q       <= BW'(BOOT_READS);
      dtack_n      <= 1'b1;
      berr_n       <= 1'b1;
      rom_enable_n <= 1'b1;
      ram_enable_n <= 1'b1;
      io_enable_n  <= 1'b1;
`ifdef GLUE_BUS_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (!as_n) begin
          state_q <= S_DECODE;
`ifdef GLUE_BUS_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        S_DECODE: begin
`ifdef GLUE_BUS_TIMEOUT_EN
          tmo_q <= tmo_q + TW'(1);
`endif
          if (as_n) state_q <= S_IDLE;
          else if (err_d) begin
            state_q <= S_ERR;
            berr_n  <= 1'b0;
          end else begin
            state_q      <= S_WAIT;
            region_q     <= region_d;
            rd_q         <= read;
            cnt_q        <= wait_d;
            rom_enable_n <= (region_d != R_ROM);
            ram_enable_n <= (region_d != R_RAM);
            io_enable_n  <= (region_d != R_IO);
          end
        end
        S_WAIT: begin
`ifdef GLUE_BUS_TIMEOUT_EN
          tmo_q <= tmo_q + TW'(1);
`endif
          if (as_n) begin
            // Abort: drop the select, no DTACK, boot count untouched.
            state_q      <= S_IDLE;
            rom_enable_n <= 1'b1;
            ram_enable_n <= 1'b1;
            io_enable_n  <= 1'b1;
          end else if (cnt_q == '0 && (region_q != R_IO || !io_ready_n)) begin
            state_q <= S_ACK;
            dtack_n <= 1'b0;
            if (rd_q && boot_q != '0) boot_q <= boot_q - BW'(1);
          end
`ifdef GLUE_BUS_TIMEOUT_EN
          else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_q      <= S_ERR;
            berr_n       <= 1'b0;
            rom_enable_n <= 1'b1;
            ram_enable_n <= 1'b1;
            io_enable_n  <= 1'b1;
          end
`endif
          else if (cnt_q != '0) cnt_q <= cnt_q - WW'(1);
        end
        S_ACK, S_ERR: if (as_n) begin
          state_q      <= S_IDLE;
          dtack_n      <= 1'b1;
          berr_n       <= 1'b1;
          rom_enable_n <= 1'b1;
          ram_enable_n <= 1'b1;
          io_enable_n  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_glue_ctrl.sv
// Randomized bench for glue_ctrl against a cycle-index reference model.
module tb_glue_ctrl;
  localparam int BOOT = 4, ROMW = 2, RAMW = 0, IOW = 3, TMO = 64;

  logic clk = 1'b0, reset_n = 1'b0;
  logic [11:0] addr_in = '0;
  logic [2:0] fc = 3'd6;
  logic as_n = 1'b1, read = 1'b1, io_ready_n = 1'b1;
  logic dtack_n, berr_n, rom_enable_n, ram_enable_n, io_enable_n;
  int tests = 0, fails = 0, boot_m = BOOT;

  glue_ctrl #(.BOOT_READS(BOOT), .ROM_WAIT(ROMW), .RAM_WAIT(RAMW), .IO_WAIT(IOW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .addr_in(addr_in), .fc(fc), .as_n(as_n), .read(read),
    .io_ready_n(io_ready_n), .dtack_n(dtack_n), .berr_n(berr_n), .rom_enable_n(rom_enable_n),
    .ram_enable_n(ram_enable_n), .io_enable_n(io_enable_n));

  always #5 clk = ~clk;

  // Output vector order: {dtack_n, berr_n, rom, ram, io}
  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {dtack_n, berr_n, rom_enable_n, ram_enable_n, io_enable_n};
  endfunction

  // One bus cycle: AS held low for edges N..N+hold, released before N+hold+1.
  // io_ready_n is sampled low from edge N+ready_at onward.
  task automatic bus_cycle(input string nm, input logic [11:0] a, input logic [2:0] f,
                           input logic rd, input int hold, input int ready_at);
    int rg, ack_k;
    bit err, tmo;
    logic [4:0] sel, exp;
    if (rd && boot_m > 0)   rg = 2;
    else if (a[11:8] < 8)   rg = 0;
    else if (a[11:8] == 14) rg = 1;
    else if (a[11:8] == 15) rg = 2;
    else                    rg = 3;
    err = (rg == 3) || (rg == 1 && !f[2]) || (rg == 2 && !rd);
    ack_k = (rg == 0) ? 2 + RAMW : (rg == 2) ? 2 + ROMW : ((ready_at > 2 + IOW) ? ready_at : 2 + IOW);
    tmo = 1'b0;
`ifdef GLUE_BUS_TIMEOUT_EN
    tmo = !err && ack_k > TMO;
`endif
    sel = (rg == 0) ? 5'b11101 : (rg == 1) ? 5'b11110 : 5'b11011;
    @(negedge clk);
    addr_in = a; fc = f; read = rd; as_n = 1'b0; io_ready_n = !(ready_at <= 0);
    for (int k = 0; k <= hold; k++) begin
      @(posedge clk); #1;
      if (k == 0)                  exp = 5'b11111;
      else if (err)                exp = 5'b10111;
      else if (tmo && k >= TMO)    exp = 5'b10111;
      else if (k >= ack_k)         exp = sel & 5'b01111;
      else                         exp = sel;
      chk($sformatf("%s k=%0d", nm, k), outs(), exp);
      @(negedge clk);
      if (k < hold) io_ready_n = !(k + 1 >= ready_at);
      else as_n = 1'b1;
    end
    @(posedge clk); #1;
    chk($sformatf("%s release", nm), outs(), 5'b11111);
    if (!err && !tmo && ack_k <= hold && rd && boot_m > 0) boot_m--;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk("reset", outs(), 5'b11111);
    @(negedge clk) reset_n = 1'b1;

    // Overlay: aborted read leaves boot count alone, then four ROM reads, fifth goes to RAM.
    bus_cycle("abort_rom", 12'h000, 3'd6, 1'b1, 1, 0);
    for (int i = 0; i < 4; i++) bus_cycle($sformatf("boot%0d", i), 12'h000, 3'd6, 1'b1, 6, 0);
    bus_cycle("ram_after_boot", 12'h000, 3'd6, 1'b1, 4, 0);
    bus_cycle("rom_write", 12'hF00, 3'd6, 1'b0, 3, 0);
    bus_cycle("user_io", 12'hE00, 3'd2, 1'b1, 3, 0);
    bus_cycle("unmapped", 12'h900, 3'd6, 1'b1, 3, 0);
    bus_cycle("io_ready10", 12'hE00, 3'd6, 1'b1, 12, 10);
    bus_cycle("io_stall", 12'hE00, 3'd6, 1'b1, 200, 100000);
    bus_cycle("ram_w0_min", 12'h123, 3'd1, 1'b0, 2, 0);

    // Reset during WAIT of an overlay read.
    @(negedge clk) reset_n = 1'b0;
    @(posedge clk); @(negedge clk) reset_n = 1'b1;
    boot_m = BOOT;
    @(negedge clk);
    addr_in = 12'h000; fc = 3'd6; read = 1'b1; as_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("pre_reset_sel", outs(), 5'b11011);
    @(negedge clk) reset_n = 1'b0;
    @(posedge clk); #1 chk("mid_reset", outs(), 5'b11111);
    @(negedge clk) begin reset_n = 1'b1; as_n = 1'b1; end
    boot_m = BOOT;

    for (int i = 0; i < 200; i++) begin
      logic [11:0] a;
      a = 12'($urandom);
      if ($urandom_range(0, 2) == 0) a[11:8] = 4'hE;
      bus_cycle($sformatf("rnd%0d", i), a, 3'($urandom), 1'($urandom_range(0, 3) != 0),
                $urandom_range(0, 14), $urandom_range(0, 12));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
